cpu_irq_ctrl: RTL and testbench

Parametrised interrupt controller that sits between the SoC interrupt sources (timer, WFI wake, DMA, EPU, peripherals) and the CPU top, replacing the two fixed interrupt wires with `NUM_SRC` prioritised, maskable sources.
- Latches each request into a pending bit through a per-source gateway (level or edge).
- Presents the CPU with a registered external-interrupt line and a separate WFI wake line.
- The CPU acknowledges through a claim/complete handshake on a small register port driven from the MEM stage.

---
 rtl/cpu_irq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cpu_irq_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_irq_ctrl.sv
// Prioritised, maskable interrupt controller between SoC interrupt sources and the CPU.
// Per-source level/edge gateway, claim/complete handshake over a small config register port.
module cpu_irq_ctrl #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned PRIO_W  = 3,
    parameter int unsigned CFG_AW  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic              cfg_we,
    input  logic              cfg_re,
    input  logic [CFG_AW-1:0] cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata,
    output logic              irq_o,
    output logic [4:0]        irq_id_o,
    output logic              wake_o
);

    localparam logic [CFG_AW-1:0] ADDR_ENABLE    = CFG_AW'(NUM_SRC);
    localparam logic [CFG_AW-1:0] ADDR_EDGE_MODE = CFG_AW'(NUM_SRC + 1);
    localparam logic [CFG_AW-1:0] ADDR_THRESHOLD = CFG_AW'(NUM_SRC + 2);
    localparam logic [CFG_AW-1:0] ADDR_CLAIM     = CFG_AW'(NUM_SRC + 3);
    localparam logic [CFG_AW-1:0] ADDR_PENDING   = CFG_AW'(NUM_SRC + 4);

    logic [PRIO_W-1:0]  prio [NUM_SRC];
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] edge_mode;
    logic [PRIO_W-1:0]  threshold;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] src_d;

    logic [NUM_SRC-1:0] candidate;
    logic [PRIO_W-1:0]  best_prio;
    logic [4:0]         best_id;
    logic               best_valid;

    logic               claim_hit;
    logic               complete_hit;
    logic [NUM_SRC-1:0] claim_mask;
    logic [NUM_SRC-1:0] complete_mask;
    logic [NUM_SRC-1:0] edge_set;
    logic [NUM_SRC-1:0] level_set;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] in_service_next;
    logic [31:0]        rd_data;

    // Strict '>' while scanning upward keeps the lowest ID on priority ties
    // and excludes priority-0 sources without a separate test.
    always_comb begin
        candidate = pending & enable;
        best_prio = '0;
        best_id   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (candidate[i] && (prio[i] > best_prio)) begin
                best_prio = prio[i];
                best_id   = 5'(i + 1);
            end
        end
    end

    assign best_valid   = (best_id != 5'd0);
    assign claim_hit    = cfg_re && (cfg_addr == ADDR_CLAIM);
    assign complete_hit = cfg_we && (cfg_addr == ADDR_CLAIM);

    always_comb begin
        claim_mask    = '0;
        complete_mask = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (claim_hit && (best_id == 5'(i + 1))) begin
                claim_mask[i] = 1'b1;
            end
            if (complete_hit && (cfg_wdata == 32'(i + 1))) begin
                complete_mask[i] = 1'b1;
            end
        end
    end

    // A level source being claimed is treated as already in service, so a
    // held request does not immediately re-pend on the claim edge.
    assign edge_set  = src_i & ~src_d & edge_mode;
    assign level_set = src_i & ~edge_mode & ~in_service & ~claim_mask;

    assign pending_next    = (pending & ~claim_mask) | edge_set | level_set;
    assign in_service_next = (in_service | claim_mask) & ~complete_mask;

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (cfg_addr == CFG_AW'(i)) begin
                rd_data = 32'(prio[i]);
            end
        end
        if (cfg_addr == ADDR_ENABLE) begin
            rd_data = 32'(enable);
        end
        if (cfg_addr == ADDR_EDGE_MODE) begin
            rd_data = 32'(edge_mode);
        end
        if (cfg_addr == ADDR_THRESHOLD) begin
            rd_data = 32'(threshold);
        end
        if (cfg_addr == ADDR_CLAIM) begin
            rd_data = 32'(best_id);
        end
        if (cfg_addr == ADDR_PENDING) begin
            rd_data = 32'(pending);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                prio[i] <= '0;
            end
            enable    <= '0;
            edge_mode <= '0;
            threshold <= '0;
        end else if (cfg_we) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (cfg_addr == CFG_AW'(i)) begin
                    prio[i] <= cfg_wdata[PRIO_W-1:0];
                end
            end
            if (cfg_addr == ADDR_ENABLE) begin
                enable <= cfg_wdata[NUM_SRC-1:0];
            end
            if (cfg_addr == ADDR_EDGE_MODE) begin
                edge_mode <= cfg_wdata[NUM_SRC-1:0];
            end
            if (cfg_addr == ADDR_THRESHOLD) begin
                threshold <= cfg_wdata[PRIO_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            in_service <= '0;
            src_d      <= '0;
        end else begin
            pending    <= pending_next;
            in_service <= in_service_next;
            src_d      <= src_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_rdata <= '0;
            irq_o     <= 1'b0;
            irq_id_o  <= '0;
            wake_o    <= 1'b0;
        end else begin
            if (cfg_re) begin
                cfg_rdata <= rd_data;
            end
            irq_o    <= best_valid && (best_prio > threshold);
            irq_id_o <= best_id;
            wake_o   <= best_valid;
        end
    end

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// Directed bench for cpu_irq_ctrl (NUM_SRC=8): register map, arbitration, gateways, claim/complete.
module tb_cpu_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  src_i = '0;
    logic        cfg_we = 1'b0;
    logic        cfg_re = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic        irq_o;
    logic [4:0]  irq_id_o;
    logic        wake_o;

    int errors = 0;
    int checks = 0;

    cpu_irq_ctrl #(.NUM_SRC(8), .PRIO_W(3), .CFG_AW(6)) dut (
        .clk(clk), .rst(rst), .src_i(src_i),
        .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .irq_o(irq_o), .irq_id_o(irq_id_o), .wake_o(wake_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic cfg_wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic cfg_rd(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        cfg_re = 1'b1; cfg_addr = a;
        @(negedge clk);
        cfg_re = 1'b0;
        d = cfg_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        checks++;
        if ({cfg_rdata, irq_o, irq_id_o, wake_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdata=%h irq=%b id=%0d wake=%b required all 0",
                     cfg_rdata, irq_o, irq_id_o, wake_o);
        end
        rst = 1'b0;
        cfg_rd(6'd12, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_pending: got %h required 0", d); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        cfg_wr(6'd4, 32'hFF);
        cfg_rd(6'd4, d);
        checks++;
        if (d !== 32'd7) begin errors++; $display("FAIL prio_mask: got %h required 7", d); end
        cfg_wr(6'd8, 32'hFF);
        cfg_rd(6'd8, d);
        checks++;
        if (d !== 32'hFF) begin errors++; $display("FAIL enable_rd: got %h required ff", d); end
        repeat (3) @(negedge clk);
        checks++;
        if (cfg_rdata !== 32'hFF) begin errors++; $display("FAIL rdata_hold: got %h required ff", cfg_rdata); end
        cfg_wr(6'd9, 32'h5A);
        cfg_rd(6'd9, d);
        checks++;
        if (d !== 32'h5A) begin errors++; $display("FAIL edge_mode_rd: got %h required 5a", d); end
        cfg_wr(6'd9, 32'h0);
        cfg_wr(6'd10, 32'hFFFF_FFFF);
        cfg_rd(6'd10, d);
        checks++;
        if (d !== 32'd7) begin errors++; $display("FAIL threshold_rd: got %h required 7", d); end
        cfg_wr(6'd10, 32'h0);
        cfg_rd(6'd20, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL unused_rd: got %h required 0", d); end
        cfg_wr(6'd12, 32'hFF);
        cfg_rd(6'd12, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL pending_ro: got %h required 0", d); end
        // simultaneous write and read: read returns pre-write value
        @(negedge clk);
        cfg_we = 1'b1; cfg_re = 1'b1; cfg_addr = 6'd8; cfg_wdata = 32'h0F;
        @(negedge clk);
        cfg_we = 1'b0; cfg_re = 1'b0; cfg_wdata = '0;
        checks++;
        if (cfg_rdata !== 32'hFF) begin errors++; $display("FAIL we_re_prewrite: got %h required ff", cfg_rdata); end
        cfg_rd(6'd8, d);
        checks++;
        if (d !== 32'h0F) begin errors++; $display("FAIL we_re_written: got %h required 0f", d); end
        cfg_wr(6'd8, 32'hFF);
    endtask

    task automatic test_priority();
        logic [31:0] d;
        cfg_wr(6'd2, 32'd5);
        cfg_wr(6'd5, 32'd5);
        cfg_wr(6'd1, 32'd3);
        @(negedge clk);
        src_i = 8'b0010_0110;
        @(negedge clk);
        src_i = '0;
        checks++;
        if (irq_id_o !== 5'd0) begin errors++; $display("FAIL prio_latency1: got %0d required 0", irq_id_o); end
        @(negedge clk);
        checks++;
        if ({irq_o, wake_o, irq_id_o} !== {1'b1, 1'b1, 5'd3}) begin
            errors++;
            $display("FAIL prio_first: got irq=%b wake=%b id=%0d required 1 1 3", irq_o, wake_o, irq_id_o);
        end
        cfg_rd(6'd11, d);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL claim_1: got %0d required 3", d); end
        @(negedge clk);
        checks++;
        if (irq_id_o !== 5'd6) begin errors++; $display("FAIL id_after_claim: got %0d required 6", irq_id_o); end
        cfg_rd(6'd11, d);
        checks++;
        if (d !== 32'd6) begin errors++; $display("FAIL claim_2: got %0d required 6", d); end
        cfg_rd(6'd11, d);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL claim_3: got %0d required 2", d); end
        cfg_rd(6'd11, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL claim_4: got %0d required 0", d); end
        cfg_wr(6'd11, 32'd3);
        cfg_wr(6'd11, 32'd6);
        cfg_wr(6'd11, 32'd2);
    endtask

    task automatic test_threshold();
        logic [31:0] d;
        cfg_wr(6'd10, 32'd5);
        cfg_wr(6'd0, 32'd5);
        @(negedge clk);
        src_i[0] = 1'b1;
        @(negedge clk);
        src_i[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({irq_o, wake_o, irq_id_o} !== {1'b0, 1'b1, 5'd1}) begin
            errors++;
            $display("FAIL thr_masked: got irq=%b wake=%b id=%0d required 0 1 1", irq_o, wake_o, irq_id_o);
        end
        cfg_wr(6'd10, 32'd4);
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL thr_write_edge: got %b required 0", irq_o); end
        @(negedge clk);
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("FAIL thr_lowered: got %b required 1", irq_o); end
        cfg_rd(6'd11, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL thr_claim: got %0d required 1", d); end
        cfg_wr(6'd11, 32'd1);
        cfg_wr(6'd10, 32'd0);
    endtask

    task automatic test_level();
        logic [31:0] d;
        @(negedge clk);
        src_i[0] = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (irq_id_o !== 5'd1) begin errors++; $display("FAIL lvl_id: got %0d required 1", irq_id_o); end
        cfg_rd(6'd11, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL lvl_claim: got %0d required 1", d); end
        repeat (2) @(negedge clk);
        cfg_rd(6'd12, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL lvl_blocked: got %h required 0", d); end
        cfg_wr(6'd11, 32'd1);
        checks++;
        if (irq_id_o !== 5'd0) begin errors++; $display("FAIL lvl_cpl_edge: got %0d required 0", irq_id_o); end
        @(negedge clk);
        checks++;
        if (irq_id_o !== 5'd0) begin errors++; $display("FAIL lvl_cpl_plus1: got %0d required 0", irq_id_o); end
        @(negedge clk);
        checks++;
        if (irq_id_o !== 5'd1) begin errors++; $display("FAIL lvl_repend: got %0d required 1", irq_id_o); end
        cfg_rd(6'd11, d);
        src_i[0] = 1'b0;
        cfg_wr(6'd11, 32'd1);
    endtask

    task automatic test_edge();
        logic [31:0] d;
        cfg_wr(6'd9, 32'h08);
        cfg_wr(6'd3, 32'd4);
        @(negedge clk);
        src_i[3] = 1'b1;
        @(negedge clk);
        src_i[3] = 1'b0;
        @(negedge clk);
        checks++;
        if (irq_id_o !== 5'd4) begin errors++; $display("FAIL edge_id: got %0d required 4", irq_id_o); end
        cfg_rd(6'd11, d);
        checks++;
        if (d !== 32'd4) begin errors++; $display("FAIL edge_claim: got %0d required 4", d); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            src_i[3] = 1'b1;
            @(negedge clk);
            src_i[3] = 1'b0;
        end
        cfg_rd(6'd12, d);
        checks++;
        if (d !== 32'h08) begin errors++; $display("FAIL edge_in_service: got %h required 08", d); end
        cfg_wr(6'd11, 32'd4);
        cfg_rd(6'd11, d);
        checks++;
        if (d !== 32'd4) begin errors++; $display("FAIL edge_reclaim: got %0d required 4", d); end
        cfg_rd(6'd11, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL edge_single: got %0d required 0", d); end
        cfg_wr(6'd11, 32'd4);
    endtask

    task automatic test_collision();
        logic [31:0] d;
        @(negedge clk);
        src_i[3] = 1'b1;
        @(negedge clk);
        src_i[3] = 1'b0;
        @(negedge clk);
        cfg_re = 1'b1; cfg_addr = 6'd11; src_i[3] = 1'b1;
        @(negedge clk);
        cfg_re = 1'b0; src_i[3] = 1'b0;
        checks++;
        if (cfg_rdata !== 32'd4) begin errors++; $display("FAIL coll_claim: got %0d required 4", cfg_rdata); end
        cfg_rd(6'd12, d);
        checks++;
        if (d !== 32'h08) begin errors++; $display("FAIL coll_set_wins: got %h required 08", d); end
        cfg_rd(6'd11, d);
        checks++;
        if (d !== 32'd4) begin errors++; $display("FAIL coll_reclaim: got %0d required 4", d); end
        cfg_wr(6'd11, 32'd4);
    endtask

    task automatic test_invalid_ids();
        logic [31:0] d;
        @(negedge clk);
        src_i[0] = 1'b1;
        repeat (2) @(negedge clk);
        cfg_rd(6'd11, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL inv_claim: got %0d required 1", d); end
        cfg_wr(6'd11, 32'd0);
        cfg_wr(6'd11, 32'd9);
        repeat (2) @(negedge clk);
        cfg_rd(6'd12, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL inv_ignored: got %h required 0", d); end
        checks++;
        if ({wake_o, irq_id_o} !== 6'd0) begin
            errors++;
            $display("FAIL inv_outputs: got wake=%b id=%0d required 0 0", wake_o, irq_id_o);
        end
        cfg_wr(6'd11, 32'd1);
        repeat (2) @(negedge clk);
        cfg_rd(6'd12, d);
        checks++;
        if (d !== 32'h01) begin errors++; $display("FAIL inv_valid_cpl: got %h required 01", d); end
        cfg_rd(6'd11, d);
        src_i[0] = 1'b0;
        cfg_wr(6'd11, 32'd1);
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        cfg_rd(6'd8, d);
        @(negedge clk);
        src_i[0] = 1'b1;
        @(negedge clk);
        src_i[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("FAIL arst_pre: got irq=%b required 1", irq_o); end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({cfg_rdata, irq_o, irq_id_o, wake_o} !== '0) begin
            errors++;
            $display("FAIL arst_outputs: got rdata=%h irq=%b id=%0d wake=%b required all 0",
                     cfg_rdata, irq_o, irq_id_o, wake_o);
        end
        @(negedge clk);
        rst = 1'b0;
        cfg_rd(6'd12, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL arst_pending: got %h required 0", d); end
        cfg_rd(6'd8, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL arst_enable: got %h required 0", d); end
        cfg_rd(6'd0, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL arst_prio: got %h required 0", d); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_priority();
        test_threshold();
        test_level();
        test_edge();
        test_collision();
        test_invalid_ids();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
